// File: rtl/axi_host_mem_slave_pkg.sv
// Shared types and protocol constants for the host-memory AXI4 slave model.
// No logic here: enums for the two channel FSMs plus response/burst encodings.
package axi_host_mem_slave_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/axi_host_mem_slave_ram.sv
// Line-wide RAM: byte-enabled write port, registered read port (1-cycle, held when re=0).
// No backpressure; rzero substitutes an all-zero line so illegal reads never expose contents.
module axi_host_mem_slave_ram #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic                    rzero,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Array itself is never reset so contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rzero ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/axi_host_mem_slave.sv
// AXI4 slave over an internal RAM; one write and one read burst in flight, channels independent.
// Registered outputs: wready/rvalid one cycle after the address handshake, 1 beat/cycle, stalls hold R.
module axi_host_mem_slave
  import axi_host_mem_slave_pkg::*;
#(
  parameter int ID_WIDTH       = 1,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int USER_WIDTH     = 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [USER_WIDTH-1:0]   s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [USER_WIDTH-1:0]   s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [USER_WIDTH-1:0]   s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [USER_WIDTH-1:0]   s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [USER_WIDTH-1:0]   s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int         OFF       = $clog2(DATA_WIDTH/8);
  localparam int         L         = MEM_DEPTH_LOG2;
  localparam int         LW        = L + 9;
  localparam logic [2:0] LINE_SIZE = 3'(OFF);

  // Full-line INCR only, window-resident, and the last line must not wrap past the top.
  function automatic logic burst_legal(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
    logic [LW-1:0] last_line;
    last_line = LW'(addr[OFF +: L]) + LW'(len);
    return (burst == BURST_INCR) && (size == LINE_SIZE) &&
           (addr[ADDR_WIDTH-1:OFF+L] == '0) && (last_line[LW-1:L] == '0);
  endfunction

  // ---------------- write channel ----------------
  w_state_e              w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [L-1:0]          w_idx;
  logic [7:0]            w_len;
  logic [7:0]            w_beat;
  logic                  w_legal;
  logic                  w_over;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ram_we;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  // Beats past len are still accepted but never reach the RAM.
  assign ram_we = w_hs && w_legal && !w_over;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      w_id          <= '0;
      w_idx         <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_legal       <= 1'b0;
      w_over        <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (aw_hs) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_id          <= s_axi_awid;
            w_idx         <= s_axi_awaddr[OFF +: L];
            w_len         <= s_axi_awlen;
            w_beat        <= '0;
            w_legal       <= burst_legal(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
            w_over        <= 1'b0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_idx  <= w_idx + L'(1);
            w_beat <= w_beat + 8'd1;
            if (s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= (w_legal && !w_over && (w_beat == w_len)) ? RESP_OKAY : RESP_SLVERR;
              w_state      <= W_RESP;
            end else if (w_beat == w_len) begin
              w_over <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state;
  logic [L-1:0]          r_nidx;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic                  r_legal;
  logic                  ar_legal;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  ram_re;
  logic                  ram_rzero;
  logic [L-1:0]          ram_raddr;

  assign ar_legal  = burst_legal(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
  assign ar_hs     = s_axi_arvalid && s_axi_arready;
  assign r_hs      = s_axi_rvalid && s_axi_rready;
  // Prefetch the next line on every non-final accept so beats go back-to-back.
  assign ram_re    = ar_hs || (r_hs && !s_axi_rlast);
  assign ram_raddr = (r_state == R_IDLE) ? s_axi_araddr[OFF +: L] : r_nidx;
  assign ram_rzero = (r_state == R_IDLE) ? !ar_legal : !r_legal;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      r_nidx        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_legal       <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rresp   <= ar_legal ? RESP_OKAY : RESP_SLVERR;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            r_len         <= s_axi_arlen;
            r_beat        <= '0;
            r_legal       <= ar_legal;
            r_nidx        <= s_axi_araddr[OFF +: L] + L'(1);
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_beat      <= r_beat + 8'd1;
              s_axi_rlast <= ((r_beat + 8'd1) == r_len);
              r_nidx      <= r_nidx + L'(1);
            end
          end
        end
      endcase
    end
  end

  axi_host_mem_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (L)
  ) u_ram (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .we    (ram_we),
    .waddr (w_idx),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .re    (ram_re),
    .rzero (ram_rzero),
    .raddr (ram_raddr),
    .rdata (s_axi_rdata)
  );

  assign s_axi_buser = '0;
  assign s_axi_ruser = '0;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                           s_axi_awuser, s_axi_wuser, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                           s_axi_arqos, s_axi_arregion, s_axi_aruser,
                           s_axi_awaddr[OFF-1:0], s_axi_araddr[OFF-1:0]};

endmodule
